// File: rtl/lfsr_period_monitor.sv
// Drives the 4-bit LFSR seed/load inputs and measures the shift count until the
// LFSR state returns to its seed, reporting the period or an error.
module lfsr_period_monitor #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] seed_in,
  input  logic [3:0] lfsr_state,
  output logic       lfsr_sel,
  output logic [3:0] lfsr_seed,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [4:0] period
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam logic [4:0] TIMEOUT_CNT = 5'(TIMEOUT);

  state_t     state_reg;
  logic [3:0] seed_reg;
  logic [4:0] cnt_reg;
  logic [4:0] period_reg;
  logic       sel_reg;
  logic       busy_reg;
  logic       done_reg;
  logic       error_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      seed_reg   <= 4'b0000;
      cnt_reg    <= 5'd0;
      period_reg <= 5'd0;
      sel_reg    <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      error_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE, ERR: begin
          if (start) begin
            seed_reg  <= seed_in;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
            // An all-zero seed would lock the LFSR, so it is rejected outright.
            if (seed_in == 4'b0000) begin
              state_reg <= ERR;
              error_reg <= 1'b1;
            end else begin
              state_reg  <= LOAD;
              busy_reg   <= 1'b1;
              sel_reg    <= 1'b0;
              period_reg <= 5'd0;
            end
          end
        end
        LOAD: begin
          cnt_reg   <= 5'd0;
          sel_reg   <= 1'b1;
          state_reg <= RUN;
        end
        RUN: begin
          if (lfsr_state == 4'b0000) begin
            state_reg <= ERR;
            busy_reg  <= 1'b0;
            error_reg <= 1'b1;
          end else if (cnt_reg != 5'd0 && lfsr_state == seed_reg) begin
            period_reg <= cnt_reg;
            state_reg  <= DONE;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
          end else if (cnt_reg == TIMEOUT_CNT) begin
            state_reg <= ERR;
            busy_reg  <= 1'b0;
            error_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 5'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          sel_reg   <= 1'b1;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          error_reg <= 1'b0;
        end
      endcase
    end
  end

  assign lfsr_sel  = sel_reg;
  assign lfsr_seed = seed_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign error     = error_reg;
  assign period    = period_reg;

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Bench for lfsr_period_monitor: a behavioural 4-bit LFSR (or scripted/stuck
// state source) closes the loop, and a trace-level model predicts each outcome.
module tb_lfsr_period_monitor;

  localparam int TO      = 15;
  localparam int CAP_LEN = 22;
  localparam int K_DONE  = 1;
  localparam int K_ERR   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] seed_in = 4'b0000;
  logic [3:0] lfsr_state;
  logic       lfsr_sel;
  logic [3:0] lfsr_seed;
  logic       busy;
  logic       done;
  logic       error;
  logic [4:0] period;

  int checks = 0;
  int failures = 0;
  int prev_period = 0;

  // Environment: mode 0 = real LFSR, 1 = stuck value, 2 = scripted per RUN cycle.
  int         mode = 0;
  logic [3:0] stuck_val = 4'b0000;
  logic [3:0] seq [64];
  logic [3:0] lfsr_q = 4'b0001;
  int         k_q = 0;

  // Observations gathered by capture().
  int         cap_done_edge, cap_err_edge, cap_done_cycles, cap_err_cycles, cap_both;
  int         cap_sel_low, cap_sel_first, cap_busy_cycles, cap_period_nz_busy;
  int         cap_seed_changes;
  logic [4:0] cap_period_end;
  logic [3:0] cap_seed_last;

  always #5 clk = ~clk;

  lfsr_period_monitor #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .seed_in(seed_in),
    .lfsr_state(lfsr_state), .lfsr_sel(lfsr_sel), .lfsr_seed(lfsr_seed),
    .busy(busy), .done(done), .error(error), .period(period)
  );

  function automatic logic [3:0] lfsr_next(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  always @(posedge clk) begin
    if (!lfsr_sel) begin
      lfsr_q <= lfsr_seed;
      k_q    <= 0;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
      if (k_q < 63) k_q <= k_q + 1;
    end
  end

  assign lfsr_state = (mode == 0) ? lfsr_q : (mode == 1) ? stuck_val : seq[k_q[5:0]];

  // Walks the sequence of states the monitor will see, shift count k = 0..TO.
  function automatic void predict(input logic [3:0] seed, output int kind,
                                  output int per, output int edge_n);
    logic [3:0] s;
    s = seed;
    kind = K_ERR;
    per = 0;
    edge_n = TO + 2;
    if (seed == 4'b0000) begin
      edge_n = 0;
      return;
    end
    for (int k = 0; k <= TO; k++) begin
      if (mode == 0) s = (k == 0) ? seed : lfsr_next(s);
      else if (mode == 1) s = stuck_val;
      else s = seq[k];
      if (s == 4'b0000) begin
        edge_n = k + 2;
        return;
      end
      if (k != 0 && s == seed) begin
        kind = K_DONE;
        per = k;
        edge_n = k + 2;
        return;
      end
    end
  endfunction

  // Issues one start and records what the outputs do over the next CAP_LEN edges.
  task automatic capture(input logic [3:0] seed, input int glitch_e);
    logic [3:0] prev_seed_out;
    prev_seed_out = 4'b0000;
    cap_done_edge = -1; cap_err_edge = -1; cap_done_cycles = 0; cap_err_cycles = 0;
    cap_both = 0; cap_sel_low = 0; cap_sel_first = -1; cap_busy_cycles = 0;
    cap_period_nz_busy = 0; cap_seed_changes = 0;
    @(negedge clk);
    seed_in = seed;
    start = 1'b1;
    for (int e = 0; e < CAP_LEN; e++) begin
      @(posedge clk);
      #1;
      if (e == 0 || e == glitch_e + 1) start = 1'b0;
      if (done) begin
        cap_done_cycles++;
        if (cap_done_edge < 0) cap_done_edge = e;
      end
      if (error) begin
        cap_err_cycles++;
        if (cap_err_edge < 0) cap_err_edge = e;
      end
      if (done && error) cap_both++;
      if (busy) begin
        cap_busy_cycles++;
        if (period != 5'd0) cap_period_nz_busy++;
      end
      if (!lfsr_sel) begin
        cap_sel_low++;
        if (cap_sel_first < 0) cap_sel_first = e;
      end
      if (e > 0 && lfsr_seed != prev_seed_out) cap_seed_changes++;
      prev_seed_out = lfsr_seed;
      if (e == glitch_e) begin
        start = 1'b1;
        seed_in = 4'b0000;
      end
    end
    start = 1'b0;
    cap_period_end = period;
    cap_seed_last = lfsr_seed;
    $display("txn seed=%b mode=%0d done_edge=%0d err_edge=%0d period=%0d busy_cycles=%0d",
             seed, mode, cap_done_edge, cap_err_edge, cap_period_end, cap_busy_cycles);
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
    checks++; if (lfsr_sel !== 1'b1) begin failures++; $display("FAIL reset_sel got=%b exp=1", lfsr_sel); end
    checks++; if (lfsr_seed !== 4'b0000) begin failures++; $display("FAIL reset_seed got=%b exp=0000", lfsr_seed); end
    checks++; if (period !== 5'd0) begin failures++; $display("FAIL reset_period got=%0d exp=0", period); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_maximal();
    mode = 0;
    capture(4'b1111, -1);
    checks++; if (cap_sel_low !== 1) begin failures++; $display("FAIL max_sel_low_cycles got=%0d exp=1", cap_sel_low); end
    checks++; if (cap_sel_first !== 0) begin failures++; $display("FAIL max_sel_low_edge got=%0d exp=0", cap_sel_first); end
    checks++; if (cap_done_edge !== 17) begin failures++; $display("FAIL max_done_edge got=%0d exp=17", cap_done_edge); end
    checks++; if (cap_period_end !== 5'd15) begin failures++; $display("FAIL max_period got=%0d exp=15", cap_period_end); end
    checks++; if (cap_err_cycles !== 0) begin failures++; $display("FAIL max_error_cycles got=%0d exp=0", cap_err_cycles); end
    checks++; if (cap_busy_cycles !== 17) begin failures++; $display("FAIL max_busy_cycles got=%0d exp=17", cap_busy_cycles); end
    prev_period = 15;
  endtask

  task automatic test_back_to_back();
    mode = 0;
    capture(4'b0001, -1);
    checks++; if (cap_done_edge !== 17) begin failures++; $display("FAIL b2b_done_edge got=%0d exp=17", cap_done_edge); end
    checks++; if (cap_done_cycles !== CAP_LEN - 17) begin failures++; $display("FAIL b2b_done_cycles got=%0d exp=%0d", cap_done_cycles, CAP_LEN - 17); end
    checks++; if (cap_period_end !== 5'd15) begin failures++; $display("FAIL b2b_period got=%0d exp=15", cap_period_end); end
    checks++; if (cap_seed_changes !== 0 || cap_seed_last !== 4'b0001) begin failures++; $display("FAIL b2b_lfsr_seed got=%b changes=%0d exp=0001 changes=0", cap_seed_last, cap_seed_changes); end
    checks++; if (cap_period_nz_busy !== 0) begin failures++; $display("FAIL b2b_period_cleared got=%0d exp=0 busy cycles with nonzero period", cap_period_nz_busy); end
    prev_period = 15;
  endtask

  task automatic test_zero_seed();
    mode = 0;
    capture(4'b0000, -1);
    checks++; if (cap_err_edge !== 0) begin failures++; $display("FAIL zero_err_edge got=%0d exp=0", cap_err_edge); end
    checks++; if (cap_err_cycles !== CAP_LEN) begin failures++; $display("FAIL zero_err_cycles got=%0d exp=%0d", cap_err_cycles, CAP_LEN); end
    checks++; if (cap_sel_low !== 0) begin failures++; $display("FAIL zero_sel_low got=%0d exp=0", cap_sel_low); end
    checks++; if (cap_busy_cycles !== 0) begin failures++; $display("FAIL zero_busy got=%0d exp=0", cap_busy_cycles); end
    checks++; if (cap_done_cycles !== 0) begin failures++; $display("FAIL zero_done got=%0d exp=0", cap_done_cycles); end
    checks++; if (32'(cap_period_end) !== prev_period) begin failures++; $display("FAIL zero_period_held got=%0d exp=%0d", cap_period_end, prev_period); end
  endtask

  task automatic test_zero_state();
    logic [3:0] s;
    mode = 2;
    s = 4'b1011;
    for (int k = 0; k < 64; k++) begin
      seq[k] = s;
      s = lfsr_next(s);
    end
    seq[5] = 4'b0000;
    capture(4'b1011, -1);
    checks++; if (cap_err_edge !== 7) begin failures++; $display("FAIL zstate_err_edge got=%0d exp=7", cap_err_edge); end
    checks++; if (cap_period_end !== 5'd0) begin failures++; $display("FAIL zstate_period got=%0d exp=0", cap_period_end); end
    checks++; if (cap_done_cycles !== 0) begin failures++; $display("FAIL zstate_done got=%0d exp=0", cap_done_cycles); end
    prev_period = 0;
  endtask

  task automatic test_stuck();
    mode = 1;
    stuck_val = 4'b0110;
    capture(4'b1001, -1);
    checks++; if (cap_err_edge !== 17) begin failures++; $display("FAIL stuck_err_edge got=%0d exp=17", cap_err_edge); end
    checks++; if (cap_done_cycles !== 0) begin failures++; $display("FAIL stuck_done got=%0d exp=0", cap_done_cycles); end
    checks++; if (cap_busy_cycles !== 17) begin failures++; $display("FAIL stuck_busy got=%0d exp=17", cap_busy_cycles); end
    checks++; if (cap_period_end !== 5'd0) begin failures++; $display("FAIL stuck_period got=%0d exp=0", cap_period_end); end
    prev_period = 0;
  endtask

  // A start sampled on the very edge that enters DONE must be ignored.
  task automatic test_busy_start();
    mode = 0;
    capture(4'b0110, 16);
    checks++; if (cap_done_edge !== 17) begin failures++; $display("FAIL edge_start_done_edge got=%0d exp=17", cap_done_edge); end
    checks++; if (cap_done_cycles !== CAP_LEN - 17) begin failures++; $display("FAIL edge_start_done_cycles got=%0d exp=%0d", cap_done_cycles, CAP_LEN - 17); end
    checks++; if (cap_err_cycles !== 0) begin failures++; $display("FAIL edge_start_error got=%0d exp=0", cap_err_cycles); end
    checks++; if (cap_seed_last !== 4'b0110) begin failures++; $display("FAIL edge_start_seed got=%b exp=0110", cap_seed_last); end
    prev_period = 15;
  endtask

  task automatic test_random();
    int kind, per, edge_n, exp_period;
    logic [3:0] seed;
    for (int it = 0; it < 12; it++) begin
      mode = ($urandom_range(1, 0) == 0) ? 0 : 2;
      seed = ($urandom_range(7, 0) == 0) ? 4'b0000 : 4'($urandom_range(15, 1));
      seq[0] = seed;
      for (int k = 1; k < 64; k++) seq[k] = 4'($urandom_range(15, 0));
      predict(seed, kind, per, edge_n);
      exp_period = (seed == 4'b0000) ? prev_period : ((kind == K_DONE) ? per : 0);
      capture(seed, -1);
      checks++; if (cap_done_edge !== ((kind == K_DONE) ? edge_n : -1)) begin failures++; $display("FAIL rnd%0d_done_edge got=%0d exp=%0d", it, cap_done_edge, (kind == K_DONE) ? edge_n : -1); end
      checks++; if (cap_err_edge !== ((kind == K_ERR) ? edge_n : -1)) begin failures++; $display("FAIL rnd%0d_err_edge got=%0d exp=%0d", it, cap_err_edge, (kind == K_ERR) ? edge_n : -1); end
      checks++; if (cap_done_cycles + cap_err_cycles !== CAP_LEN - edge_n) begin failures++; $display("FAIL rnd%0d_flag_hold got=%0d exp=%0d", it, cap_done_cycles + cap_err_cycles, CAP_LEN - edge_n); end
      checks++; if (cap_both !== 0) begin failures++; $display("FAIL rnd%0d_flags_exclusive got=%0d exp=0", it, cap_both); end
      checks++; if (32'(cap_period_end) !== exp_period) begin failures++; $display("FAIL rnd%0d_period got=%0d exp=%0d", it, cap_period_end, exp_period); end
      checks++; if (cap_busy_cycles !== ((seed != 4'b0000) ? edge_n : 0)) begin failures++; $display("FAIL rnd%0d_busy got=%0d exp=%0d", it, cap_busy_cycles, (seed != 4'b0000) ? edge_n : 0); end
      checks++; if (cap_sel_low !== ((seed != 4'b0000) ? 1 : 0)) begin failures++; $display("FAIL rnd%0d_sel_low got=%0d exp=%0d", it, cap_sel_low, (seed != 4'b0000) ? 1 : 0); end
      checks++; if (cap_seed_last !== seed) begin failures++; $display("FAIL rnd%0d_lfsr_seed got=%b exp=%b", it, cap_seed_last, seed); end
      prev_period = exp_period;
    end
  endtask

  task automatic test_reset_mid_run();
    mode = 0;
    @(negedge clk);
    seed_in = 4'b1111;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    seed_in = 4'b0000;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || error !== 1'b0) begin failures++; $display("FAIL midrun_start_ignored got busy=%b error=%b exp busy=1 error=0", busy, error); end
    #2 rst = 1'b0;
    #1;
    $display("txn reset asserted at RUN cycle 7");
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrun_busy got=%b exp=0", busy); end
    checks++; if (lfsr_sel !== 1'b1) begin failures++; $display("FAIL midrun_sel got=%b exp=1", lfsr_sel); end
    checks++; if (lfsr_seed !== 4'b0000) begin failures++; $display("FAIL midrun_seed got=%b exp=0000", lfsr_seed); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done !== 1'b0 || error !== 1'b0) begin failures++; $display("FAIL midrun_flags got done=%b error=%b exp 0 0", done, error); end
    @(negedge clk);
    rst = 1'b1;
    prev_period = 0;
    capture(4'b1111, -1);
    checks++; if (cap_done_edge !== 17) begin failures++; $display("FAIL after_reset_done_edge got=%0d exp=17", cap_done_edge); end
    checks++; if (cap_period_end !== 5'd15) begin failures++; $display("FAIL after_reset_period got=%0d exp=15", cap_period_end); end
  endtask

  initial begin
    test_reset();
    test_maximal();
    test_back_to_back();
    test_zero_seed();
    test_zero_state();
    test_stuck();
    test_busy_start();
    test_random();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_period_monitor.md
# lfsr_period_monitor

Control-and-check stage wrapped around the 4-bit LFSR. It accepts a seed request from the host and drives the LFSR's `sel`/`seed` load inputs. It then watches the LFSR `state` output and counts shift cycles until the state returns to the seed, reporting the measured period or an error. It is the LFSR's upstream driver and downstream consumer in the lab's sequence-generator datapath.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum shift count checked before declaring failure; `period` is 5 bits, so `TIMEOUT` ≤ 31.

Ports:
- `clk` in 1: single system clock, rising-edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `start` in 1: request a measurement; sampled only when `busy`=0.
- `seed_in` in 4: seed to load; captured on the accepted `start`.
- `lfsr_state` in 4: current LFSR state output.
- `lfsr_sel` out 1: LFSR mux select; 0 = parallel load, 1 = shift.
- `lfsr_seed` out 4: seed presented to the LFSR parallel-load inputs.
- `busy` out 1: high in LOAD and RUN.
- `done` out 1: high while in DONE.
- `error` out 1: high while in ERR.
- `period` out 5: measured period; valid while `done`=1.

## Operation
- State machine has five states: IDLE, LOAD, RUN, DONE, ERR.
- **IDLE / DONE / ERR:** on `start`=1:
  - capture `seed_in` into `seed_reg`.
  - if `seed_in`=0000, go to ERR.
  - otherwise go to LOAD.
  - with `start`=0, hold the current state.
- **LOAD** (exactly one cycle):
  - `lfsr_sel`=0, `lfsr_seed`=`seed_reg`.
  - clear `cnt`; go to RUN.
- **RUN:** `lfsr_sel`=1, `lfsr_seed`=`seed_reg`. Each cycle, checks apply in this priority:
  1. `lfsr_state`=0000 → ERR (LFSR reset or stuck).
  2. `cnt`≠0 and `lfsr_state`=`seed_reg` → `period`←`cnt`, go to DONE.
  3. `cnt`=`TIMEOUT` → ERR.
  4. otherwise `cnt`←`cnt`+1.
- `cnt` is 5 bits and never wraps, because rule 3 fires first.
- **Output values by state:**
  - `lfsr_sel`=1 in every state except LOAD.
  - `lfsr_seed` holds `seed_reg` in all states.
  - `period` holds its last value until the next DONE.
  - `period` is cleared to 0 on entry to LOAD.
- **Flag behaviour:**
  - `done` and `error` are mutually exclusive.
  - Each stays high until the next accepted `start`, and falls in the cycle that start is sampled.
  - Re-`start` from DONE or ERR is legal.
- `start` while `busy`=1 is ignored. There is no abort; only `rst` abandons a measurement.

## Timing
- **Reset** (asynchronous, immediate):
  - state = IDLE.
  - `seed_reg`=0, `cnt`=0.
  - `lfsr_sel`=1, `lfsr_seed`=0000.
  - `busy`=0, `done`=0, `error`=0, `period`=0.
- **Reset mid-RUN:** outputs go to reset values without waiting for a clock edge; no `done` or `error` is produced.
- All outputs are registered or decoded from state only (Moore); nothing depends combinationally on `start`.
- **Edge timeline** (E0 = edge where `start` is sampled):
  - E0 → LOAD; `busy`=1 and `lfsr_sel`=0 for cycle E0–E1.
  - E1: LFSR loads the seed; monitor enters RUN.
  - RUN cycle k (following edge E(k+2)): `lfsr_state` = seed shifted k times, `cnt`=k.
- **Maximal 4-bit LFSR:** match at k=15.
  - DONE entered at E17, with `period`=15.
  - `done` rises 17 edges after E0; `busy` falls at the same edge.
- **Zero seed:** ERR entered at E0; `error`=1 one cycle after `start`; LOAD never occurs.
- **Timeout:** ERR entered at edge E(TIMEOUT+2) if no match.
- **Simultaneous `start` and state change:** the state change wins. A start sampled in the same cycle the FSM enters DONE is not seen, because `busy` was still 1.

## Test plan
- **Seed 1111, LFSR in loop:** `start` pulse → `lfsr_sel`=0 for exactly 1 cycle; `done`=1 and `period`=15 at E17; `error`=0.
- **Back-to-back re-start:** seed 0001 `start` from DONE → `done` drops at E0; `period`=15 again at E17; `lfsr_seed`=0001 throughout.
- **Zero seed:** `seed_in`=0000 `start` → `error`=1 after 1 cycle; `lfsr_sel` stays 1; `busy` never asserts.
- **Stuck LFSR model:** `lfsr_state` forced to 0110 constantly, seed 1001, `TIMEOUT`=15 → `error`=1 at E17; `done` never asserts.
- **Zero state during RUN:** force `lfsr_state`=0000 at RUN cycle 5 → `error` rises the next cycle; `period` stays 0.
- **Reset mid-RUN:** `rst`=0 at RUN cycle 7 → all outputs at reset values immediately; `start` ignored while `busy`=1; new `start` after `rst`=1 gives `period`=15.
